pixel_cnt_frontend_cr: RTL and testbench

Continuous-readout counting back end for one pixel. It takes NUM_CH asynchronous hit pulses, for example the local-arbiter winner and the summing-mode pulse, and synchronises them into clk_read. Each channel is counted in a saturating binary counter gated by its own shutter. On a latch pulse every count is frozen into a shadow shift register, and counting restarts with no dead time. Shadow registers daisy-chain pixel-to-pixel through ser_in/ser_out, so frame N shifts out while frame N+1 accumulates.

---
 rtl/pixel_fe_pkg.sv | 22 ++
 rtl/pixel_cnt_frontend_cr_hit_sync_counter.sv | 60 ++++++
 rtl/pixel_cnt_frontend_cr.sv | 88 ++++++++
 tb/tb_pixel_cnt_frontend_cr.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_fe_pkg.sv
// Shared constants, shadow-word layout and helpers for the pixel counting front end.
package pixel_fe_pkg;

   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_CNT_WIDTH   = 12;
   localparam int DEF_SYNC_STAGES = 2;

   // Shadow word: overflow flag sits directly above the count, so it shifts out first.
   typedef struct packed {
      logic                     ovf;
      logic [DEF_CNT_WIDTH-1:0] cnt;
   } shadow_word_t;

   function automatic int ovf_pos(input int cnt_width);
      return cnt_width;
   endfunction

   function automatic logic [31:0] sat_value(input int cnt_width);
      return (32'd1 << cnt_width) - 32'd1;
   endfunction

endpackage

// File: rtl/pixel_cnt_frontend_cr_hit_sync_counter.sv
// One counting channel: hit synchroniser, rising-edge detect, shutter gate,
// saturating counter with sticky overflow, and the frame-boundary restart on latch.
module hit_sync_counter
   import pixel_fe_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 hit_i,
   input  logic                 shutter_i,
   input  logic                 latch_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 ovf_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(sat_value(CNT_WIDTH));

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   count_evt;

   assign count_evt = sync_q[SYNC_STAGES-1] & ~edge_q & shutter_i;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (latch_i) begin
         // A boundary event is handed to the new frame, never to the frozen one.
         cnt_d = count_evt ? CNT_WIDTH'(1) : '0;
         ovf_d = 1'b0;
      end else if (count_evt) begin
         if (cnt_q == CNT_MAX) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: state uses non-blocking assignments; the combinational block above uses blocking ones.
      if (!rst_ni) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hit_i};
         edge_q <= sync_q[SYNC_STAGES-1];
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/pixel_cnt_frontend_cr.sv
// Pixel counting back end: per-channel counters plus the double-buffered shadow
// shift chain that carries frame N downstream while frame N+1 accumulates.
module pixel_cnt_frontend_cr
   import pixel_fe_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk_read,
   input  logic              reset,
   input  logic [NUM_CH-1:0] hit_in,
   input  logic [NUM_CH-1:0] shutter,
   input  logic              latch,
   input  logic              shift_en,
   input  logic [NUM_CH-1:0] ser_in,
   output logic [NUM_CH-1:0] ser_out,
   output logic [NUM_CH-1:0] ovf,
   output logic              busy,
   output logic              frame_lost
);

   localparam int WORD_W   = CNT_WIDTH + 1;
   localparam int OVF_BIT  = ovf_pos(CNT_WIDTH);
   localparam int BITCNT_W = $clog2(WORD_W + 1);

   logic [CNT_WIDTH-1:0] cnt [NUM_CH];
   logic [WORD_W-1:0]    shadow_q [NUM_CH];
   logic [WORD_W-1:0]    shadow_d [NUM_CH];
   logic [NUM_CH-1:0]    ser_out_q, ser_out_d;
   logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
   logic                 frame_lost_q, frame_lost_d;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      hit_sync_counter #(
         .CNT_WIDTH  (CNT_WIDTH),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_cnt (
         .clk_i    (clk_read),
         .rst_ni   (reset),
         .hit_i    (hit_in[g]),
         .shutter_i(shutter[g]),
         .latch_i  (latch),
         .cnt_o    (cnt[g]),
         .ovf_o    (ovf[g])
      );
   end

   assign busy = (bitcnt_q != '0);

   always_comb begin
      shadow_d     = shadow_q;
      ser_out_d    = ser_out_q;
      bitcnt_d     = bitcnt_q;
      frame_lost_d = 1'b0;
      if (latch) begin
         // Latch overrides a simultaneous shift; an unfinished readout is flagged as lost.
         for (int i = 0; i < NUM_CH; i++) shadow_d[i] = {ovf[i], cnt[i]};
         bitcnt_d     = BITCNT_W'(WORD_W);
         frame_lost_d = busy;
      end else if (shift_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i]  = {shadow_q[i][CNT_WIDTH-1:0], ser_in[i]};
            ser_out_d[i] = shadow_q[i][OVF_BIT];
         end
         if (busy) bitcnt_d = bitcnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_read or negedge reset) begin
      if (!reset) begin
         // NOTE: the shadow words are a handful of flops, not a RAM, so they are reset like any register.
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
         ser_out_q    <= '0;
         bitcnt_q     <= '0;
         frame_lost_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         ser_out_q    <= ser_out_d;
         bitcnt_q     <= bitcnt_d;
         frame_lost_q <= frame_lost_d;
      end
   end

   assign ser_out    = ser_out_q;
   assign frame_lost = frame_lost_q;

endmodule

// File: tb/tb_pixel_cnt_frontend_cr.sv
// Self-checking bench: table of counting scenarios plus hand-written frame-boundary sequences.
module tb_pixel_cnt_frontend_cr;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] hit_in, shutter, ser_in;
   logic       latch, shift_en, latch4, shift4;
   logic [1:0] ser_out, ovf, ser_out4, ovf4;
   logic       busy, frame_lost, busy4, frame_lost4;

   always #5 clk = ~clk;

   pixel_cnt_frontend_cr dut (
      .clk_read(clk), .reset(reset), .hit_in(hit_in), .shutter(shutter),
      .latch(latch), .shift_en(shift_en), .ser_in(ser_in),
      .ser_out(ser_out), .ovf(ovf), .busy(busy), .frame_lost(frame_lost)
   );

   pixel_cnt_frontend_cr #(.NUM_CH(2), .CNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .clk_read(clk), .reset(reset), .hit_in(hit_in), .shutter(shutter),
      .latch(latch4), .shift_en(shift4), .ser_in(ser_in),
      .ser_out(ser_out4), .ovf(ovf4), .busy(busy4), .frame_lost(frame_lost4)
   );

   typedef struct {
      int          ch;
      int          n_off;
      int          n_on;
      logic [12:0] exp0;
      logic [12:0] exp1;
   } vec_t;

   vec_t       vecs [4];
   logic [1:0] sb_q [$];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      hit_in = '0; shutter = '0; ser_in = '0;
      latch = 1'b0; shift_en = 1'b0; latch4 = 1'b0; shift4 = 1'b0;
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
   endtask

   // One hit: high two cycles, low two cycles; detection and count finish inside.
   task automatic pulse(input int ch, input logic sh);
      hit_in[ch] = 1'b1; shift_en = sh; tick();
      shift_en = 1'b0;                  tick();
      hit_in[ch] = 1'b0; shift_en = sh; tick();
      shift_en = 1'b0;                  tick();
   endtask

   task automatic latch_pulse(input bit narrow);
      if (narrow) latch4 = 1'b1; else latch = 1'b1;
      tick();
      latch4 = 1'b0; latch = 1'b0;
   endtask

   // Shifts nshift bits, expecting word bits MSB first; busy expected to fall on the last bit.
   task automatic shift_out(input logic [31:0] w0, input logic [31:0] w1, input int nbits,
                            input int nshift, input bit narrow, input bit chk_busy);
      for (int k = 0; k < nshift; k++) begin
         logic [1:0] e;
         e = {w1[nbits-1-k], w0[nbits-1-k]};
         sb_q.push_back(e);
         if (narrow) shift4 = 1'b1; else shift_en = 1'b1;
         tick();
         shift4 = 1'b0; shift_en = 1'b0;
         e = sb_q.pop_front();
         check($sformatf("ser_out bit %0d", k), 32'(narrow ? ser_out4 : ser_out), 32'(e));
         if (chk_busy)
            check($sformatf("busy after shift %0d", k), 32'(narrow ? busy4 : busy),
                  32'(k < nbits - 1));
      end
   endtask

   initial begin
      vecs[0] = '{ch: 0, n_off: 0, n_on: 5, exp0: 13'd5, exp1: 13'd0};
      vecs[1] = '{ch: 0, n_off: 3, n_on: 2, exp0: 13'd2, exp1: 13'd0};
      vecs[2] = '{ch: 1, n_off: 0, n_on: 7, exp0: 13'd0, exp1: 13'd7};
      vecs[3] = '{ch: 1, n_off: 2, n_on: 3, exp0: 13'd0, exp1: 13'd3};

      hit_in = '0; shutter = '0; ser_in = '0;
      latch = 1'b0; shift_en = 1'b0; latch4 = 1'b0; shift4 = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("reset ser_out", 32'(ser_out), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset frame_lost", 32'(frame_lost), 32'd0);

      foreach (vecs[v]) begin
         do_reset();
         shutter = 2'b11;
         shutter[vecs[v].ch] = 1'b0;
         repeat (vecs[v].n_off) pulse(vecs[v].ch, 1'b0);
         shutter[vecs[v].ch] = 1'b1;
         repeat (vecs[v].n_on) pulse(vecs[v].ch, 1'b0);
         check($sformatf("vec%0d ovf", v), 32'(ovf), 32'd0);
         latch_pulse(1'b0);
         check($sformatf("vec%0d busy after latch", v), 32'(busy), 32'd1);
         check($sformatf("vec%0d frame_lost", v), 32'(frame_lost), 32'd0);
         shift_out(32'(vecs[v].exp0), 32'(vecs[v].exp1), 13, 13, 1'b0, 1'b1);
      end

      // Hit detected in the latch cycle belongs to the new frame.
      do_reset();
      shutter = 2'b11;
      repeat (3) pulse(0, 1'b0);
      hit_in[0] = 1'b1; tick(); tick();
      latch = 1'b1; tick();
      latch = 1'b0; hit_in[0] = 1'b0; tick(); tick();
      shift_out(32'd3, 32'd0, 13, 13, 1'b0, 1'b1);
      latch_pulse(1'b0);
      check("coincident frame_lost", 32'(frame_lost), 32'd0);
      shift_out(32'd1, 32'd0, 13, 13, 1'b0, 1'b1);

      // Re-latch after 6 shifts: frame lost, busy reloads; counting continues while shifting.
      do_reset();
      shutter = 2'b11;
      repeat (2) pulse(0, 1'b0);
      latch_pulse(1'b0);
      check("lost first latch", 32'(frame_lost), 32'd0);
      repeat (3) pulse(1, 1'b1);
      check("lost busy before relatch", 32'(busy), 32'd1);
      latch = 1'b1; tick();
      latch = 1'b0;
      check("lost pulse", 32'(frame_lost), 32'd1);
      tick();
      check("lost pulse width", 32'(frame_lost), 32'd0);
      shift_out(32'd0, 32'd3, 13, 13, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a readout.
      do_reset();
      shutter = 2'b11;
      repeat (2) pulse(0, 1'b0);
      latch_pulse(1'b0);
      shift_out(32'd2, 32'd0, 13, 7, 1'b0, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("midreset ser_out", 32'(ser_out), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset ovf", 32'(ovf), 32'd0);
      tick();
      reset = 1'b1;
      ser_in = 2'b11;
      tick();
      shift_out(32'd0, 32'd0, 13, 13, 1'b0, 1'b0);
      check("post-reset busy", 32'(busy), 32'd0);
      shift_en = 1'b1; tick();
      shift_en = 1'b0;
      check("passthrough ser_out", 32'(ser_out), 32'd3);
      ser_in = 2'b00;

      // Narrow counter saturation and overflow.
      do_reset();
      shutter = 2'b11;
      repeat (20) pulse(1, 1'b0);
      check("narrow ovf before latch", 32'(ovf4), 32'd2);
      check("wide ovf at 20 hits", 32'(ovf), 32'd0);
      latch_pulse(1'b1);
      check("narrow ovf after latch", 32'(ovf4), 32'd0);
      shift_out(32'd0, 32'h1F, 5, 5, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
